// File: rtl/unary_add_1_12.sv
// Unary adder: accumulates A+B pulses into a 12-bit count, then drains it as a unary dout stream.
// Build option: define UNARY_ADD_SATURATE_EN to clamp count at 4095 on overflow instead of wrapping.
module unary_add_1_12 (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic en,
    input  logic read_or_write,
    output logic dout,
    output logic C
);

    // Stream semantics: there is no valid/ready pair. While en=1 and read_or_write=1,
    // dout=1 on a cycle means one unit has been removed from count on the edge that
    // produced it; a value N therefore appears as exactly N back-to-back dout=1 cycles.

    logic [11:0] count;
    logic [11:0] count_nxt;
    logic [12:0] sum;
    logic [11:0] sum_fit;
    logic        dout_nxt;
    logic        c_q;
    logic        c_nxt;

    // 13-bit sum so the carry out of the 12-bit accumulator is observable
    assign sum = {1'b0, count} + {12'd0, A} + {12'd0, B};

`ifdef UNARY_ADD_SATURATE_EN
    assign sum_fit = sum[12] ? 12'hFFF : sum[11:0];
`else
    assign sum_fit = sum[11:0];
`endif

    always_comb begin
        count_nxt = count;
        dout_nxt  = 1'b0;
        c_nxt     = c_q;
        if (en) begin
            if (read_or_write) begin
                if (count != 12'd0) begin
                    dout_nxt  = 1'b1;
                    count_nxt = count - 12'd1;
                end
            end else begin
                count_nxt = sum_fit;
                if (sum[12]) begin
                    c_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 12'd0;
            dout  <= 1'b0;
            c_q   <= 1'b0;
        end else begin
            count <= count_nxt;
            dout  <= dout_nxt;
            c_q   <= c_nxt;
        end
    end

    assign C = c_q;

endmodule

// File: tb/tb_unary_add_1_12.sv
// Directed bench for unary_add_1_12: driver pushes expected {count, C, dout} per edge,
// a monitor pops and compares after each rising edge.
`timescale 1ns/1ps
module tb_unary_add_1_12;

    logic clk;
    logic rst_n;
    logic A;
    logic B;
    logic en;
    logic read_or_write;
    logic dout;
    logic C;

    unary_add_1_12 dut (
        .clk(clk),
        .rst_n(rst_n),
        .A(A),
        .B(B),
        .en(en),
        .read_or_write(read_or_write),
        .dout(dout),
        .C(C)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int ones_seen = 0;

    logic [13:0] exp_q[$];

    logic [11:0] m_count;
    logic        m_c;
    logic        m_dout;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one call = one rising edge of stimulus, expected result queued
    task automatic step(input logic e, input logic rw, input logic a, input logic b);
        int s;
        @(negedge clk);
        en = e;
        read_or_write = rw;
        A = a;
        B = b;
        if (!e) begin
            m_dout = 1'b0;
        end else if (rw) begin
            if (m_count != 12'd0) begin
                m_dout  = 1'b1;
                m_count = m_count - 12'd1;
            end else begin
                m_dout = 1'b0;
            end
        end else begin
            s = int'(m_count) + int'(a) + int'(b);
            m_dout = 1'b0;
            if (s > 4095) begin
                m_c = 1'b1;
`ifdef UNARY_ADD_SATURATE_EN
                s = 4095;
`else
                s = s - 4096;
`endif
            end
            m_count = s[11:0];
        end
        exp_q.push_back({m_count, m_c, m_dout});
    endtask

    // wait for the edge of the last step and confirm the monitor consumed it
    task automatic settle();
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // called right after settle(): asserts reset between edges and checks it acts at once
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        en = 1'b0;
        A = 1'b0;
        B = 1'b0;
        read_or_write = 1'b0;
        #1;
        chk("rst_count", int'(dut.count), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_c", int'(C), 0);
        m_count = 12'd0;
        m_c = 1'b0;
        m_dout = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor / scoreboard
    always begin
        logic [13:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", int'(dut.count), int'(e[13:2]));
            chk("c", int'(C), int'(e[1]));
            chk("dout", int'(dout), int'(e[0]));
            if (dout) ones_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        A = 1'b0;
        B = 1'b0;
        read_or_write = 1'b0;
        m_count = 12'd0;
        m_c = 1'b0;
        m_dout = 1'b0;
        #12;
        chk("init_count", int'(dut.count), 0);
        chk("init_dout", int'(dout), 0);
        chk("init_c", int'(C), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // A=B=1 for 10 cycles -> 20
        for (int i = 0; i < 10; i++) step(1, 0, 1, 1);
        settle();
        chk("add20_count", int'(dut.count), 20);
        chk("add20_c", int'(C), 0);
        chk("add20_dout", int'(dout), 0);
        do_reset();

        // 5x A, 3x B -> 8; A=B=0 adds nothing
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        settle();
        chk("add8_count", int'(dut.count), 8);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        settle();
        chk("add0_count", int'(dut.count), 8);

        // one drain edge, then disabled with A=B=1 in write mode
        step(1, 1, 1, 1);
        settle();
        chk("drain1_count", int'(dut.count), 7);
        chk("drain1_dout", int'(dout), 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
        settle();
        chk("hold_count", int'(dut.count), 7);
        chk("hold_dout", int'(dout), 0);
        do_reset();

        // count=5, drain for 20 cycles with A/B toggling (ignored)
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
        settle();
        ones_seen = 0;
        for (int i = 0; i < 20; i++) step(1, 1, i[0], 1);
        settle();
        chk("drain_ones", ones_seen, 5);
        chk("drain_count", int'(dut.count), 0);
        chk("drain_c", int'(C), 0);
        do_reset();

        // 2049 double pulses: overflow on the 2048th
        for (int i = 1; i <= 2049; i++) begin
            step(1, 0, 1, 1);
            if (i == 2047) begin
                settle();
                chk("pre_ovf_count", int'(dut.count), 4094);
                chk("pre_ovf_c", int'(C), 0);
            end
            if (i == 2048) begin
                settle();
                chk("ovf_c", int'(C), 1);
            end
            step(1, 0, 0, 0);
        end
        settle();
`ifdef UNARY_ADD_SATURATE_EN
        chk("ovf_final_count", int'(dut.count), 4095);
`else
        chk("ovf_final_count", int'(dut.count), 2);
`endif
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        settle();
        chk("sticky_c", int'(C), 1);
`ifdef UNARY_ADD_SATURATE_EN
        chk("sticky_count", int'(dut.count), 4092);
`else
        chk("sticky_count", int'(dut.count), 0);
`endif
        do_reset();

        // reset mid-drain, then normal operation resumes cleanly
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        settle();
        chk("mid_count", int'(dut.count), 4);
        chk("mid_dout", int'(dout), 1);
        do_reset();
        step(1, 0, 1, 1);
        settle();
        chk("post_rst_count", int'(dut.count), 2);
        chk("post_rst_c", int'(C), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unary_add_1_12.md
UNARY_ADD_1_12 -- requirements
Module: unary_add_1_12

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port A  input  1  unary operand bit; weight 1 per cycle sampled high.
REQ-005 Port B  input  1  unary operand bit; weight 1 per cycle sampled high.
REQ-006 Port en  input  1  block enable; low = hold all state.
REQ-007 Port read_or_write  input  1  mode select: 0 = accumulate (write), 1 = unary drain (read).
REQ-008 Port dout  output  1  registered serial unary output stream.
REQ-009 Port C  output  1  registered sticky carry/overflow flag.
REQ-010 Internal accumulator named count SHALL be 12 bits, unsigned, range 0..4095, and hierarchically visible for monitoring.

Function
REQ-011 Write mode (en=1, read_or_write=0): each rising edge, count <= count + A + B, using a 13-bit intermediate sum.
REQ-012 Write mode: if the 13-bit sum exceeds 4095, C SHALL be set to 1 on that edge.
REQ-013 Write mode, default build: on overflow, count SHALL wrap modulo 4096, e.g. 4095+2 -> 1.
REQ-014 Write mode: dout SHALL be driven 0.
REQ-015 Read mode (en=1, read_or_write=1), count != 0: dout <= 1 and count <= count-1 on each edge.
REQ-016 Read mode, count == 0: dout <= 0; count stays 0 and does not underflow.
REQ-017 Read mode: A and B SHALL be ignored.
REQ-018 Read mode: draining a value N SHALL produce exactly N consecutive dout=1 cycles, with the first 1 visible one cycle after the first read-mode edge.
REQ-019 en=0: count and C SHALL hold; dout <= 0 on the next edge.
REQ-020 C SHALL be sticky; once set it SHALL clear only on reset, and it is unaffected by mode changes or by count returning to 0.
REQ-021 A mode switch SHALL take effect on the first edge at which the new read_or_write value is sampled, with no idle cycle inserted.
REQ-022 A=B=1 in one write cycle SHALL add 2; A=B=0 SHALL add 0.

Reset
REQ-023 rst_n=0 SHALL immediately force count=0, dout=0 and C=0, independent of clk.
REQ-024 Reset asserted mid-accumulate or mid-drain SHALL abort the operation with no residual state.
REQ-025 After rst_n deasserts, normal operation SHALL begin at the next rising edge.

Configuration
REQ-026 Macro UNARY_ADD_SATURATE_EN, when defined, SHALL make count saturate at 4095 on write-mode overflow instead of wrapping, with C still set; e.g. 4095+2 -> 4095.
REQ-027 When UNARY_ADD_SATURATE_EN is undefined, wrap behaviour per REQ-013 SHALL apply.

Verification
REQ-028 Reset, then en=1 and write mode with A=B=1 for 10 cycles -> count=20, C=0, dout=0.
REQ-029 Write mode, A=1 and B=0 for 5 cycles, then A=0 and B=1 for 3 cycles -> count=8.
REQ-030 2049 write pulses of A=B=1 (one edge each, alternating with A=B=0) -> C=1 after the 2048th pulse; final count=2 by default, or 4095 with UNARY_ADD_SATURATE_EN.
REQ-031 count=5, switch to read mode for 20 cycles -> dout=1 for exactly 5 cycles then 0; count=0; C unchanged.
REQ-032 count=7, en=0 for 10 cycles with A=B=1 in write mode -> count stays 7 and dout=0.
REQ-033 Assert rst_n=0 mid-drain and between clock edges -> count, dout and C all 0 immediately.
